fmul_share_ctrl: RTL and testbench

//  Shares one fully pipelined single-precision multiplier (fmul_norm as its last stage) among NREQ requesters.

---
 rtl/fmul_share_ctrl_if.sv | 32 +++
 rtl/fmul_share_ctrl.sv | 122 ++++++++++++
 tb/tb_fmul_share_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_share_ctrl_if.sv
// Bundles the requester, shared-multiplier and response signals of fmul_share_ctrl.
// slave = the controller itself; master = requesters plus the multiplier datapath.
interface fmul_share_ctrl_if #(
    parameter int NREQ = 4
);
    // Handshakes: an op moves when req_valid[i] & req_ready[i]; a result moves
    // when rsp_valid[i] & rsp_ready[i]. req_ready never depends on rsp_ready, and
    // rsp_valid/rsp_s hold until the consuming cycle.
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [2*NREQ-1:0]    req_rm;
    logic [NREQ-1:0]      req_ready;
    logic                 mul_issue;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic [1:0]           mul_rm;
    logic [31:0]          mul_s;
    logic [NREQ-1:0]      rsp_valid;
    logic [32*NREQ-1:0]   rsp_s;
    logic [NREQ-1:0]      rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, req_rm, mul_s, rsp_ready,
        output req_ready, mul_issue, mul_a, mul_b, mul_rm, rsp_valid, rsp_s
    );

    modport master (
        output req_valid, req_a, req_b, req_rm, mul_s, rsp_ready,
        input  req_ready, mul_issue, mul_a, mul_b, mul_rm, rsp_valid, rsp_s
    );
endinterface

// File: rtl/fmul_share_ctrl.sv
// Round-robin sharing of one pipelined fmul among NREQ requesters, with a tag
// shadow pipe routing each result into a per-requester one-entry response buffer.
module fmul_share_ctrl #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    fmul_share_ctrl_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]              ptr_q, ptr_d;
    logic [NREQ-1:0]            busy_q, busy_d;
    logic [NREQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0][31:0]      rsp_s_q, rsp_s_d;
    logic [LAT-1:0]             tag_vld_q, tag_vld_d;
    logic [PW-1:0]              tag_idx_q [LAT];
    logic [PW-1:0]              tag_idx_d [LAT];

    logic [NREQ-1:0]            eligible;
    logic [NREQ-1:0]            grant;
    logic                       gnt_any;
    logic [PW-1:0]              gnt_idx;
    logic [PW:0]                scan_sum;
    logic [NREQ-1:0]            rsp_hs;
    logic [31:0]                mul_a_c, mul_b_c;
    logic [1:0]                 mul_rm_c;

    assign rsp_hs = rsp_valid_q & bus.rsp_ready;

    // First eligible index scanning from ptr with wrap; suppressed while in reset.
    always_comb begin
        eligible = bus.req_valid & ~busy_q;
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            if (!gnt_any && !rst && eligible[scan_sum[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_sum[PW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && gnt_idx == PW'(i)) begin
                grant[i] = 1'b1;
            end
        end
    end

    // Select only through the one-hot grant so idle requesters' operands never leak.
    always_comb begin
        mul_a_c  = '0;
        mul_b_c  = '0;
        mul_rm_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_a_c  = bus.req_a[32*i +: 32];
                mul_b_c  = bus.req_b[32*i +: 32];
                mul_rm_c = bus.req_rm[2*i +: 2];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        busy_d      = (busy_q | grant) & ~rsp_hs;
        rsp_valid_d = rsp_valid_q & ~rsp_hs;
        rsp_s_d     = rsp_s_q;
        tag_vld_d   = tag_vld_q;
        tag_idx_d   = tag_idx_q;
        tag_vld_d[0] = gnt_any;
        tag_idx_d[0] = gnt_idx;
        for (int k = 1; k < LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end
        // The target buffer is always empty here: busy blocks re-issue until consumed.
        for (int i = 0; i < NREQ; i++) begin
            if (tag_vld_q[LAT-1] && tag_idx_q[LAT-1] == PW'(i)) begin
                rsp_valid_d[i] = 1'b1;
                rsp_s_d[i]     = bus.mul_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_s_q     <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_idx_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.mul_issue = gnt_any;
    assign bus.mul_a     = mul_a_c;
    assign bus.mul_b     = mul_b_c;
    assign bus.mul_rm    = mul_rm_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_s     = rsp_s_q;
endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Bench for fmul_share_ctrl: a toy pipelined multiplier, a per-requester
// behavioural model compared every cycle, and directed literal scenarios.
module tb_fmul_share_ctrl;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmul_share_ctrl_if #(.NREQ(NREQ)) bus();

    fmul_share_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Toy multiplier: exponent-add approximation, so 2.0*3.0 gives exactly 6.0.
    function automatic logic [31:0] toy_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        return a + b - 32'h3F80_0000 + {30'b0, rm};
    endfunction

    // Stand-in datapath: result due k+1 cycles from now sits in slot k.
    logic [31:0] mp_d [LAT];
    bit          mp_v [LAT];

    always @(posedge clk) begin
        #1;
        bus.mul_s = mp_v[0] ? mp_d[0] : $urandom;
    end

    // Behavioural model, per requester.
    int          m_ptr = 0;
    bit          m_known = 1'b0;
    bit          m_busy [NREQ];
    int          m_rem  [NREQ];
    logic [31:0] m_val  [NREQ];
    bit          m_rv   [NREQ];
    logic [31:0] m_rs   [NREQ];

    always @(negedge clk) begin : cmp_blk
        int g;
        int idx;
        logic [NREQ-1:0]      exp_gnt;
        logic [31:0]          exp_a, exp_b;
        logic [1:0]           exp_rm;
        logic [NREQ-1:0]      exp_rv;
        logic [32*NREQ-1:0]   exp_rs;

        g = -1;
        exp_gnt = '0;
        exp_a = '0;
        exp_b = '0;
        exp_rm = '0;
        if (rst !== 1'b1) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[idx] === 1'b1 && !m_busy[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_gnt[g] = 1'b1;
            exp_a  = bus.req_a[32*g +: 32];
            exp_b  = bus.req_b[32*g +: 32];
            exp_rm = bus.req_rm[2*g +: 2];
        end
        check("req_ready", 128'(bus.req_ready), 128'(exp_gnt));
        check("mul_issue", 128'(bus.mul_issue), 128'(g >= 0));
        check("mul_a", 128'(bus.mul_a), 128'(exp_a));
        check("mul_b", 128'(bus.mul_b), 128'(exp_b));
        check("mul_rm", 128'(bus.mul_rm), 128'(exp_rm));
        if (m_known) begin
            for (int i = 0; i < NREQ; i++) begin
                exp_rv[i] = m_rv[i];
                exp_rs[32*i +: 32] = m_rs[i];
            end
            check("rsp_valid", 128'(bus.rsp_valid), 128'(exp_rv));
            check("rsp_s", 128'(bus.rsp_s), 128'(exp_rs));
        end

        if (rst === 1'b1) begin
            m_known = 1'b1;
            m_ptr = 0;
            for (int i = 0; i < NREQ; i++) begin
                m_busy[i] = 1'b0;
                m_rem[i]  = 0;
                m_rv[i]   = 1'b0;
                m_rs[i]   = '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_rv[i] && bus.rsp_ready[i] === 1'b1) begin
                    m_rv[i]   = 1'b0;
                    m_busy[i] = 1'b0;
                end
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_rv[i] = 1'b1;
                        m_rs[i] = m_val[i];
                    end
                end
            end
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_rem[g]  = LAT;
                m_val[g]  = toy_mul(exp_a, exp_b, exp_rm);
                m_ptr     = (g + 1) % NREQ;
            end
        end

        for (int k = 0; k < LAT - 1; k++) begin
            mp_d[k] = mp_d[k+1];
            mp_v[k] = mp_v[k+1];
        end
        mp_v[LAT-1] = (bus.mul_issue === 1'b1);
        mp_d[LAT-1] = toy_mul(bus.mul_a, bus.mul_b, bus.mul_rm);
    end

    task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
        @(posedge clk);
        #1;
        rst = r;
        bus.req_valid = v;
        bus.rsp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                bus.req_a[32*i +: 32] = $urandom;
                bus.req_b[32*i +: 32] = $urandom;
                bus.req_rm[2*i +: 2]  = 2'($urandom_range(0, 3));
            end else begin
                bus.req_a[32*i +: 32] = 'x;
                bus.req_b[32*i +: 32] = 'x;
                bus.req_rm[2*i +: 2]  = 'x;
            end
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_rm[2*i +: 2]  = rm;
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, '0, '1);
    endtask

    initial begin
        logic [NREQ-1:0] gseen;
        int gcnt;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_rm = '0;
        bus.mul_s = '0;
        for (int k = 0; k < LAT; k++) mp_v[k] = 1'b0;

        // Reset held two cycles with every requester asking.
        for (int c = 0; c < 2; c++) begin
            step(1'b1, '1, '1);
            @(negedge clk);
            check("rst_req_ready", 128'(bus.req_ready), 128'(4'b0000));
            check("rst_mul_issue", 128'(bus.mul_issue), 128'(1'b0));
            if (c == 1) check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0000));
        end

        // Contention with every response consumed immediately.
        gseen = '0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, '1, '1);
            @(negedge clk);
            gseen = gseen | bus.req_ready;
            if (k < 4) check("cont_order", 128'(bus.req_ready), 128'(4'b0001 << k));
            if (k == 4) check("cont_gap", 128'(bus.req_ready), 128'(4'b0000));
            if (k == 5) check("cont_regrant0", 128'(bus.req_ready), 128'(4'b0001));
        end
        check("cont_nostarve", 128'(gseen), 128'(4'b1111));
        drain(8);

        // Wrap: steer ptr to 3, then only 0 and 3 eligible.
        step(1'b1, '0, '1);
        step(1'b0, 4'b0100, '1);
        @(negedge clk);
        check("wrap_g2", 128'(bus.req_ready), 128'(4'b0100));
        step(1'b0, 4'b1001, '1);
        @(negedge clk);
        check("wrap_g3", 128'(bus.req_ready), 128'(4'b1000));
        step(1'b0, 4'b1001, '1);
        @(negedge clk);
        check("wrap_g0", 128'(bus.req_ready), 128'(4'b0001));
        drain(6);
        step(1'b0, 4'b0011, '1);
        @(negedge clk);
        check("wrap_ptr1", 128'(bus.req_ready), 128'(4'b0010));
        drain(6);

        // Single op: 2.0 * 3.0 on requester 1.
        step(1'b0, 4'b0010, '0);
        set_op(1, 32'h4000_0000, 32'h4040_0000, 2'd0);
        @(negedge clk);
        check("single_grant", 128'(bus.req_ready), 128'(4'b0010));
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, '0, '0);
            @(negedge clk);
            check("single_rv", 128'(bus.rsp_valid[1]), 128'(k == 4));
            if (k == 4) check("single_rs", 128'(bus.rsp_s[63:32]), 128'(32'h40C0_0000));
        end
        drain(4);

        // Backpressure on requester 2 for ten cycles.
        gcnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b0100, '0);
            if (k == 0) set_op(2, 32'h3F80_0000, 32'h4000_0000, 2'd1);
            @(negedge clk);
            if (bus.req_ready[2] === 1'b1) gcnt++;
            if (k == 0) check("bp_grant", 128'(bus.req_ready), 128'(4'b0100));
            if (k >= 4) begin
                check("bp_rv", 128'(bus.rsp_valid[2]), 128'(1'b1));
                check("bp_rs_stable", 128'(bus.rsp_s[95:64]), 128'(32'h4000_0001));
            end
        end
        check("bp_one_issue", 128'(gcnt), 128'(1));
        step(1'b0, 4'b0100, 4'b0100);
        @(negedge clk);
        check("bp_hs_nogrant", 128'(bus.req_ready), 128'(4'b0000));
        step(1'b0, 4'b0100, '0);
        @(negedge clk);
        check("bp_regrant", 128'(bus.req_ready), 128'(4'b0100));
        check("bp_rs_hold", 128'(bus.rsp_s[95:64]), 128'(32'h4000_0001));
        drain(8);

        // Reset while requester 3's op is in flight.
        step(1'b0, 4'b1000, '1);
        @(negedge clk);
        check("mid_grant", 128'(bus.req_ready), 128'(4'b1000));
        step(1'b1, '0, '1);
        @(negedge clk);
        check("mid_rst_ready", 128'(bus.req_ready), 128'(4'b0000));
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, '1);
            @(negedge clk);
            check("mid_no_rsp", 128'(bus.rsp_valid[3]), 128'(1'b0));
        end
        step(1'b0, 4'b1000, '1);
        @(negedge clk);
        check("mid_regrant", 128'(bus.req_ready), 128'(4'b1000));
        drain(6);

        // Random traffic with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 199) == 0), NREQ'($urandom), NREQ'($urandom));
        end
        drain(8);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
